// File: rtl/req_demux_in.sv
// req_demux_in: input-side request router for one calc1 port.
// A port command arrives with operand 1, and operand 2 follows on the next
// cycle. The decoded request is queued in a small FIFO. The FIFO head is then
// sent to the add/sub unit or the shift unit over valid/ready. An illegal
// command is answered locally with an invalid-command response.
// Optional build macro: REQ_DEMUX_STATS_EN adds saturating dispatch/overrun
// counters (n_add, n_shf, n_inv, n_ovr).
module req_demux_in #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              c_clk,
  input  logic              reset_n,
  input  logic [0:3]        req_cmd,
  input  logic [0:DATA_W-1] req_data,
  output logic              port_busy,
  output logic              add_vld,
  input  logic              add_rdy,
  output logic [0:3]        add_cmd,
  output logic              shf_vld,
  input  logic              shf_rdy,
  output logic [0:3]        shf_cmd,
  output logic [0:DATA_W-1] op1,
  output logic [0:DATA_W-1] op2,
  output logic [0:1]        inv_resp,
  output logic [0:DATA_W-1] inv_data
`ifdef REQ_DEMUX_STATS_EN
  ,
  output logic [0:7]        n_add,
  output logic [0:7]        n_shf,
  output logic [0:7]        n_inv,
  output logic [0:7]        n_ovr
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, OP2} state_e;

  typedef struct packed {
    logic [0:3]        cmd;
    logic [0:DATA_W-1] op1;
    logic [0:DATA_W-1] op2;
  } entry_t;

  state_e            state_q, state_d;
  logic [0:3]        cap_cmd_q, cap_cmd_d;
  logic [0:DATA_W-1] cap_op1_q, cap_op1_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  entry_t            mem_q [FIFO_DEPTH];

  entry_t head;
  logic   not_empty, is_add, is_shf, inv_hit;
  logic   push, pop, accept, drop;

  // The head entry is decoded to a valid for one unit, or to an invalid response.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it unassigned and infers a latch.
    head      = mem_q[rd_ptr_q];
    not_empty = (count_q != '0);
    is_add    = (head.cmd == 4'd1) || (head.cmd == 4'd2);
    is_shf    = (head.cmd == 4'd5) || (head.cmd == 4'd6);
    add_vld   = not_empty && is_add;
    shf_vld   = not_empty && is_shf;
    inv_hit   = not_empty && !is_add && !is_shf;
    add_cmd   = add_vld ? head.cmd : 4'd0;
    shf_cmd   = shf_vld ? head.cmd : 4'd0;
    op1       = not_empty ? head.op1 : '0;
    op2       = not_empty ? head.op2 : '0;
    inv_resp  = inv_hit ? 2'b10 : 2'b00;
    inv_data  = '0;
    port_busy = (count_q == CNT_W'(FIFO_DEPTH));
    // An invalid head is answered in its single cycle at the head and leaves unconditionally.
    pop       = (add_vld && add_rdy) || (shf_vld && shf_rdy) || inv_hit;
  end

  // Capture FSM: operand 1 arrives with the command, and operand 2 on the next cycle.
  always_comb begin
    state_d   = state_q;
    cap_cmd_d = cap_cmd_q;
    cap_op1_d = cap_op1_q;
    accept    = 1'b0;
    drop      = 1'b0;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_cmd != 4'd0) begin
          if (port_busy) begin
            drop = 1'b1;
          end else begin
            accept    = 1'b1;
            cap_cmd_d = req_cmd;
            cap_op1_d = req_data;
            state_d   = OP2;
          end
        end
      end
      OP2: begin
        // A slot is always free here because this FSM is the only producer.
        push    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointers and occupancy. A push and a pop in the same cycle cancel out.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state: reset discards any in-flight capture and empties the FIFO.
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
      state_q   <= IDLE;
      cap_cmd_q <= '0;
      cap_op1_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cap_cmd_q <= cap_cmd_d;
      cap_op1_q <= cap_op1_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Entry payload storage, written only on push.
  // NOTE: the payload array is not reset. Every read of it is gated by count_q, so a reset would add nothing.
  always_ff @(posedge c_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{cmd: cap_cmd_q, op1: cap_op1_q, op2: req_data};
    end
  end

`ifdef REQ_DEMUX_STATS_EN
  logic [0:7] n_add_q, n_add_d, n_shf_q, n_shf_d, n_inv_q, n_inv_d, n_ovr_q, n_ovr_d;

  function automatic logic [0:7] sat_inc(input logic [0:7] v, input logic en);
    return (en && (v != 8'hFF)) ? v + 8'd1 : v;
  endfunction

  // Event counters saturate at 8'hFF.
  always_comb begin
    n_add_d = sat_inc(n_add_q, add_vld && add_rdy);
    n_shf_d = sat_inc(n_shf_q, shf_vld && shf_rdy);
    n_inv_d = sat_inc(n_inv_q, inv_hit);
    n_ovr_d = sat_inc(n_ovr_q, drop);
  end

  // Counter registers, cleared on reset.
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      n_add_q <= '0;
      n_shf_q <= '0;
      n_inv_q <= '0;
      n_ovr_q <= '0;
    end else begin
      n_add_q <= n_add_d;
      n_shf_q <= n_shf_d;
      n_inv_q <= n_inv_d;
      n_ovr_q <= n_ovr_d;
    end
  end

  assign n_add = n_add_q;
  assign n_shf = n_shf_q;
  assign n_inv = n_inv_q;
  assign n_ovr = n_ovr_q;
`endif

endmodule
